// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames,
// folds E0/F0 prefixes into per-key flags and queues key events in a FWFT FIFO.
module ps2_scan_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned DEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 10;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Synchronizers idle high so reset never creates a falling edge
  logic r_clk_s1, r_clk_s2, r_clk_d, r_fall;
  logic r_dat_s1, r_dat_s2, r_dat_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_dat_d  <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_dat_d  <= r_dat_s2;
      r_fall   <= r_clk_d & ~r_clk_s2;
    end
  end

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TW-1:0]   r_to_cnt;
  logic            r_byte_done;
  logic [7:0]      r_byte;
  logic            r_frame_err;

  // Frame deframer with inter-edge timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_done <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_d) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {r_dat_d, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= r_dat_d;
            r_state <= ST_STOP;
          end
          default: begin
            if (r_dat_d && (^{r_shift, r_par})) begin
              r_byte_done <= 1'b1;
              r_byte      <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_to_cnt    <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  logic          r_ext_pend, r_brk_pend;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_head;
  logic          r_valid, r_ovf;

  logic          w_push, w_pop, w_full, w_wr;
  logic [EW-1:0] w_entry, w_head_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;

  // Head of the FIFO for the next cycle, so outputs can be registered
  always_comb begin
    w_push      = r_byte_done && (r_byte != CODE_EXT) && (r_byte != CODE_BRK);
    w_pop       = key_ack && (r_count != '0);
    w_full      = (r_count == CW'(DEPTH));
    w_wr        = w_push && (!w_full || w_pop);
    w_entry     = {r_ext_pend, r_brk_pend, r_byte};
    w_rptr_nxt  = r_rptr + AW'(w_pop);
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    w_head_nxt  = '0;
    if (w_count_nxt != '0) begin
      if (w_wr && (r_wptr == w_rptr_nxt)) w_head_nxt = w_entry;
      else                                w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_frame_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (r_byte_done) begin
        if (r_byte == CODE_EXT)      r_ext_pend <= 1'b1;
        else if (r_byte == CODE_BRK) r_brk_pend <= 1'b1;
        else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
      if (w_wr) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign key_code  = r_head[7:0];
  assign key_break = r_head[8];
  assign key_ext   = r_head[9];
  assign key_valid = r_valid;
  assign frame_err = r_frame_err;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: a PS/2 frame driver plus a model of prefix
// folding and FIFO occupancy; expected key events are queued as frames are sent.
module tb_ps2_scan_rx;

  localparam int unsigned TO    = 500;
  localparam int unsigned DEPTH = 4;
  localparam int          HP    = 50;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, key_ack;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, frame_err, overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_seen = 0;
  int         m_err = 0;
  logic       m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  ps2_scan_rx #(.TIMEOUT_CYCLES(TO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .key_ack(key_ack), .frame_err(frame_err),
    .overflow(overflow)
  );

  // Drives n bits LSB first; returns right after the last ps2_clk fall
  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (HP) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip, input logic stop,
                            input logic settle);
    logic par;
    par = (~^code) ^ flip;
    ps2_bits({stop, par, code, 1'b0}, 11);
    if (!flip && stop) begin
      if (code == 8'hE0) m_ext = 1'b1;
      else if (code == 8'hF0) m_brk = 1'b1;
      else begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, code});
        else m_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_err++;
    end
    if (settle) repeat (10) @(negedge clk);
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({key_code, key_ext, key_break, key_valid, frame_err, overflow} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {key_code, key_ext, key_break, key_valid, frame_err, overflow});
    end
  endtask

  task automatic test_single();
    logic [9:0] e;
    do_ack();  // ack while empty must be ignored
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++; $display("FAIL latency_early: key_valid got %b required 0", key_valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL single_head: got %h required %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, e});
    end
    do_ack();
    n_cmp++;
    if ({key_valid, key_code} !== 9'd0) begin
      n_bad++; $display("FAIL single_pop: got %h required 0", {key_valid, key_code});
    end
  endtask

  task automatic test_prefix();
    logic [9:0] e;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++; $display("FAIL f0_no_entry: key_valid got %b required 0", key_valid);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL prefix_head%0d: got %h required %h", k,
                 {key_valid, key_ext, key_break, key_code}, {1'b1, e});
      end
      do_ack();
    end
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++; $display("FAIL prefix_empty: key_valid got %b required 0", key_valid);
    end
  endtask

  task automatic test_frame_err();
    logic [9:0] e;
    int         err0;
    err0 = err_seen;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
    send_frame(8'h2C, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ((err_seen - err0) !== 2) begin
      n_bad++; $display("FAIL err_pulses: got %0d required 2", err_seen - err0);
    end
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_no_push: key_valid got %b required 0", key_valid);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL err_recover: got %h required %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, e});
    end
    do_ack();
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    int         err0;
    err0 = err_seen;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    ps2_bits(11'b101_0110_1010, 5);
    repeat (TO + 50) @(negedge clk);
    m_ext = 1'b0;
    m_brk = 1'b0;
    n_cmp++;
    if ((err_seen - err0) !== 1) begin
      n_bad++; $display("FAIL timeout_err: pulses got %0d required 1", err_seen - err0);
    end
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h required %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, e});
    end
    do_ack();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    logic [9:0] e;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int k = 0; k < 5; k++) send_frame(codes[k], 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (overflow !== m_ovf) begin
      n_bad++; $display("FAIL overflow_set: got %b required %b", overflow, m_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'd0;
      n_cmp++;
      if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL ovf_head%0d: got %h required %h", k,
                 {key_valid, key_ext, key_break, key_code}, {1'b1, e});
      end
      do_ack();
    end
    n_cmp++;
    if ({key_valid, overflow} !== {1'b0, m_ovf}) begin
      n_bad++;
      $display("FAIL ovf_drained: valid/ovf got %b%b required 0%b", key_valid, overflow, m_ovf);
    end
    do_reset();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_reset: got %b required 0", overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] e;
    ps2_bits(11'b111_1111_0010, 4);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    do_reset();
    send_frame(8'h45, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL reset_mid_frame: got %h required %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, e});
    end
    do_ack();
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    key_ack  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_prefix();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 keyboard receiver that sits directly upstream of the scan-code-to-ASCII converter. It samples the raw `ps2_clk`/`ps2_data` lines and deframes 11-bit PS/2 frames with parity, stop and timeout checking. It folds `E0`/`F0` prefix bytes into per-key flags and buffers the resulting key events in a small FIFO for the CPU I/O port. `key_code` carries the raw set-2 scan code, which feeds the converter unchanged.

## Interface
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a `ps2_clk` falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `key_code`  out  8  scan code of the FIFO head entry.
- `key_ext`  out  1  head entry was preceded by `E0`.
- `key_break`  out  1  head entry was preceded by `F0` (key release).
- `key_valid`  out  1  FIFO is non-empty.
- `key_ack`  in  1  pops the head entry in a cycle where `key_valid` is 1.
- `frame_err`  out  1  one-cycle pulse on a parity, stop or timeout error.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- **Synchronizer**
  - 2-FF synchronizer on each PS/2 line, plus one delay register on the synced clock.
  - Synchronizer registers reset to 1 (bus idle), so reset never produces a spurious edge.
  - `fall` = previous synced clock high AND current synced clock low. It lasts one cycle.
  - The data line passes through an equal-depth pipeline, so `ps2_data` is sampled aligned with `fall`.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP; all transitions occur only on `fall`)
  - IDLE: if data = 0 (start bit), go to DATA and clear `bit_cnt`. If data = 1, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit (`bit_cnt` = 7), go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: the frame is good if stop = 1 and the 8 data bits plus the parity bit contain an odd number of ones. A good frame pulses internal `byte_done` for one cycle; a bad frame pulses `frame_err`. In both cases, return to IDLE.
- **Timeout**
  - A counter clears on every `fall` and while in IDLE.
  - In any non-IDLE state, when the counter reaches `TIMEOUT_CYCLES`-1, go to IDLE and pulse `frame_err`. No byte is emitted.
- **Prefix decoder** (acts on `byte_done`)
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`.
  - Any other byte: push {`ext_pend`, `brk_pend`, byte} into the FIFO, then clear both pend flags.
  - `E1` and the Pause sequence get no special handling; each non-prefix byte is pushed as an ordinary code.
  - Any `frame_err` clears both pend flags.
- **FIFO**
  - Entries are 10 bits wide, first-word fall-through: outputs always show the head entry.
  - Outputs are 0 while the FIFO is empty.
  - `key_ack` while empty is ignored.
  - A push while full drops the new entry and sets `overflow`.
  - Push and pop in the same cycle while full: both occur, and `overflow` is not set.
  - Push while empty with `key_ack` high in the same cycle: the ack is ignored and the push occurs.
  - `overflow` clears only on reset.
- **Reset**
  - FSM goes to IDLE; FIFO empties; pend flags, counters and `bit_cnt` clear.
  - Outputs `key_code`=0, `key_ext`=0, `key_break`=0, `key_valid`=0, `frame_err`=0, `overflow`=0.
  - Reset asserted mid-frame discards that frame. The next frame is accepted only from its start bit.

## Timing
- `fall` asserts 3 `clk` cycles after the `ps2_clk` pin falls.
- `byte_done` or `frame_err` asserts in the cycle after the stop-bit `fall`.
- The FIFO push occurs on the `byte_done` cycle. `key_valid` and the head entry are visible the next cycle.
- Total latency from the stop-bit pin edge to `key_valid`: 5 `clk`.
- Pop: after a `key_ack` cycle, the next entry, or empty, is visible on the following cycle.
- `clk` must be at least 100× the PS/2 clock (10–16.7 kHz).

## Test plan
- Frame `0x1C`, parity 0 → `key_valid`=1, `key_code`=`0x1C`, `key_ext`=0, `key_break`=0 at 5 `clk` after the stop edge. `key_ack` → `key_valid`=0.
- Frames `F0`, `1C` → exactly one entry: `key_code`=`0x1C`, `key_break`=1, `key_ext`=0. No entry is created for `F0`.
- Frames `E0`, `F0`, `75` → one entry: `key_code`=`0x75`, `key_ext`=1, `key_break`=1.
- `F0` good, then `0x1C` with parity 1 → `frame_err` pulses one cycle and no entry is pushed. Then `0x1C` good → entry with `key_break`=0.
- 5 `ps2_clk` falls, then a stall longer than `TIMEOUT_CYCLES` → `frame_err` pulse and FSM in IDLE. Then a good `0x16` frame → `key_code`=`0x16`.
- `DEPTH`=4, five good codes `16`, `1E`, `26`, `25`, `2E` with no ack → `overflow`=1. Four acks yield `16`, `1E`, `26`, `25`, then `key_valid`=0; `overflow` remains 1 until `rst_n`=0.
